// File: rtl/regfile_pkg.sv
// Shared constants for the scoreboarded register file and its read ports.
// Latency: n/a (package only).
// Backpressure: n/a.
package regfile_pkg;

    localparam int DEF_DATA_W   = 32;
    localparam int DEF_ADDR_W   = 5;
    localparam int DEF_NUM_REGS = 32;

    // Address of the optional hardwired-zero register.
    localparam int ZERO_ADDR = 0;

    // True when addr selects an implemented register.
    function automatic logic addr_in_range(input logic [31:0] addr, input int n);
        return addr < 32'(n);
    endfunction

endpackage

// File: rtl/regfile_rdport.sv
// One registered read port: range check, zero-register masking, write bypass, output flops.
// Latency: 1 cycle from rd_en/ard to dout/busy_out; outputs hold while rd_en=0.
// Backpressure: none; rd_en acts as a hold/enable for the output register.
//
// Ports: clk/rst (async active-high); rd_en, ard = read request;
//        wr_vld/awr/din = write accepted by the storage this cycle (for bypass);
//        regs/busy = current (pre-edge) storage and busy vector;
//        dout/busy_out = registered read data and busy flag.
module regfile_rdport
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int NUM_REGS = DEF_NUM_REGS,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            rd_en,
    input  logic [ADDR_W-1:0]               ard,
    input  logic                            wr_vld,
    input  logic [ADDR_W-1:0]               awr,
    input  logic [DATA_W-1:0]               din,
    input  logic [NUM_REGS-1:0][DATA_W-1:0] regs,
    input  logic [NUM_REGS-1:0]             busy,
    output logic [DATA_W-1:0]               dout,
    output logic                            busy_out
);

    logic [DATA_W-1:0] sel_dat;
    logic              sel_busy;
    logic [DATA_W-1:0] dout_d, dout_q;
    logic              busy_d, busy_q;

    always_comb begin
        sel_dat  = '0;
        sel_busy = 1'b0;
        // Compare-and-select rather than indexing, so an out-of-range
        // address never indexes past the implemented storage.
        for (int i = 0; i < NUM_REGS; i++) begin
            if (ard == ADDR_W'(i)) begin
                sel_dat  = regs[i];
                sel_busy = busy[i];
            end
        end
        // A forwarded write always reads as not busy, even if the same
        // register is being reserved on this edge; that reservation is
        // only seen by the next read.
        if ((BYPASS != 0) && wr_vld && (awr == ard)) begin
            sel_dat  = din;
            sel_busy = 1'b0;
        end
        // Masking comes last so it overrides both storage and bypass.
        if (!addr_in_range(32'(ard), NUM_REGS) ||
            ((ZERO_REG != 0) && (ard == ADDR_W'(ZERO_ADDR)))) begin
            sel_dat  = '0;
            sel_busy = 1'b0;
        end

        dout_d = dout_q;
        busy_d = busy_q;
        if (rd_en) begin
            dout_d = sel_dat;
            busy_d = sel_busy;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dout_q <= '0;
            busy_q <= 1'b0;
        end else begin
            dout_q <= dout_d;
            busy_q <= busy_d;
        end
    end

    assign dout     = dout_q;
    assign busy_out = busy_q;

endmodule

// File: rtl/regfile_sb.sv
// 2-read/1-write register file with per-register busy scoreboard for RAW hazard detection.
// Latency: reads 1 cycle (registered, optional write bypass); writes/reservations take effect at the edge.
// Backpressure: none; RdEn=0 holds the read outputs, writes and reservations always proceed.
//
// Ports: Clk, Rst (async active-high);
//        Ard1/Ard2, RdEn = read addresses and shared read enable;
//        Awr/Din/WrEn = write (also clears busy[Awr]);
//        Ares/ResEn = reservation (sets busy[Ares], wins over a same-cycle write);
//        Dout1/Dout2, Busy1/Busy2 = registered read data and busy flags.
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int NUM_REGS = DEF_NUM_REGS,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic [ADDR_W-1:0] Ard1,
    input  logic [ADDR_W-1:0] Ard2,
    input  logic              RdEn,
    input  logic [ADDR_W-1:0] Awr,
    input  logic [DATA_W-1:0] Din,
    input  logic              WrEn,
    input  logic [ADDR_W-1:0] Ares,
    input  logic              ResEn,
    output logic [DATA_W-1:0] Dout1,
    output logic [DATA_W-1:0] Dout2,
    output logic              Busy1,
    output logic              Busy2
);

    logic [NUM_REGS-1:0][DATA_W-1:0] regs_d, regs_q;
    logic [NUM_REGS-1:0]             busy_d, busy_q;
    logic                            wr_vld;
    logic                            res_vld;

    // Writes and reservations to unimplemented or hardwired-zero
    // addresses are dropped here, so register 0 storage stays zero.
    always_comb begin
        wr_vld  = WrEn && addr_in_range(32'(Awr), NUM_REGS) &&
                  !((ZERO_REG != 0) && (Awr == ADDR_W'(ZERO_ADDR)));
        res_vld = ResEn && addr_in_range(32'(Ares), NUM_REGS) &&
                  !((ZERO_REG != 0) && (Ares == ADDR_W'(ZERO_ADDR)));
    end

    always_comb begin
        regs_d = regs_q;
        busy_d = busy_q;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (wr_vld && (Awr == ADDR_W'(i))) begin
                regs_d[i] = Din;
                busy_d[i] = 1'b0;
            end
            // Applied after the write so a same-cycle reservation wins.
            if (res_vld && (Ares == ADDR_W'(i))) begin
                busy_d[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            regs_q <= '0;
            busy_q <= '0;
        end else begin
            regs_q <= regs_d;
            busy_q <= busy_d;
        end
    end

    regfile_rdport #(
        .DATA_W  (DATA_W),
        .ADDR_W  (ADDR_W),
        .NUM_REGS(NUM_REGS),
        .ZERO_REG(ZERO_REG),
        .BYPASS  (BYPASS)
    ) u_rd1 (
        .clk     (Clk),
        .rst     (Rst),
        .rd_en   (RdEn),
        .ard     (Ard1),
        .wr_vld  (wr_vld),
        .awr     (Awr),
        .din     (Din),
        .regs    (regs_q),
        .busy    (busy_q),
        .dout    (Dout1),
        .busy_out(Busy1)
    );

    regfile_rdport #(
        .DATA_W  (DATA_W),
        .ADDR_W  (ADDR_W),
        .NUM_REGS(NUM_REGS),
        .ZERO_REG(ZERO_REG),
        .BYPASS  (BYPASS)
    ) u_rd2 (
        .clk     (Clk),
        .rst     (Rst),
        .rd_en   (RdEn),
        .ard     (Ard2),
        .wr_vld  (wr_vld),
        .awr     (Awr),
        .din     (Din),
        .regs    (regs_q),
        .busy    (busy_q),
        .dout    (Dout2),
        .busy_out(Busy2)
    );

endmodule

// File: tb/tb_regfile_sb.sv
// Scoreboard bench for regfile_sb: a default instance (bypass, zero reg, 32 regs)
// and a variant (no bypass, no zero reg, 24 regs) driven with identical stimulus.
// Expected outputs are pushed per edge and popped by an independent monitor.
module tb_regfile_sb;

    typedef struct packed {
        logic [31:0] d1;
        logic        b1;
        logic [31:0] d2;
        logic        b2;
    } exp_t;

    // Per-configuration rules: index 0 = default instance, 1 = variant.
    localparam int NR [2] = '{32, 24};
    localparam int ZR [2] = '{1, 0};
    localparam int BP [2] = '{1, 0};

    logic        Clk = 1'b0;
    logic        Rst = 1'b1;
    logic [4:0]  Ard1 = '0, Ard2 = '0, Awr = '0, Ares = '0;
    logic        RdEn = 1'b0, WrEn = 1'b0, ResEn = 1'b0;
    logic [31:0] Din = '0;

    logic [31:0] a_d1, a_d2, b_d1, b_d2;
    logic        a_b1, a_b2, b_b1, b_b2;

    int checks = 0;
    int failures = 0;

    exp_t q_a[$];
    exp_t q_b[$];

    // Behavioural model state.
    logic [31:0] m_reg  [2][32];
    logic        m_busy [2][32];
    logic [31:0] h_d1 [2], h_d2 [2];
    logic        h_b1 [2], h_b2 [2];

    always #5 Clk = ~Clk;

    regfile_sb dut_a (
        .Clk(Clk), .Rst(Rst), .Ard1(Ard1), .Ard2(Ard2), .RdEn(RdEn),
        .Awr(Awr), .Din(Din), .WrEn(WrEn), .Ares(Ares), .ResEn(ResEn),
        .Dout1(a_d1), .Dout2(a_d2), .Busy1(a_b1), .Busy2(a_b2)
    );

    regfile_sb #(.NUM_REGS(24), .ZERO_REG(0), .BYPASS(0)) dut_b (
        .Clk(Clk), .Rst(Rst), .Ard1(Ard1), .Ard2(Ard2), .RdEn(RdEn),
        .Awr(Awr), .Din(Din), .WrEn(WrEn), .Ares(Ares), .ResEn(ResEn),
        .Dout1(b_d1), .Dout2(b_d2), .Busy1(b_b1), .Busy2(b_b2)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
        end
    endtask

    function automatic void model_reset();
        for (int c = 0; c < 2; c++) begin
            for (int r = 0; r < 32; r++) begin
                m_reg[c][r]  = '0;
                m_busy[c][r] = 1'b0;
            end
            h_d1[c] = '0; h_d2[c] = '0; h_b1[c] = 1'b0; h_b2[c] = 1'b0;
        end
    endfunction

    function automatic logic writable(input int c, input int a);
        return (a < NR[c]) && !(ZR[c] != 0 && a == 0);
    endfunction

    // Value a read of address a returns after the edge, given this cycle's write.
    function automatic logic [32:0] model_read(input int c, input int a,
                                               input logic wr, input int aw,
                                               input logic [31:0] din);
        if (!writable(c, a)) return '0;
        if (BP[c] != 0 && wr && aw == a) return {din, 1'b0};
        return {m_reg[c][a], m_busy[c][a]};
    endfunction

    task automatic cycle(input logic rd, input int a1, input int a2,
                         input logic wr, input int aw, input logic [31:0] din,
                         input logic res, input int ar);
        exp_t e [2];
        logic [32:0] r;
        RdEn = rd; Ard1 = 5'(a1); Ard2 = 5'(a2);
        WrEn = wr; Awr = 5'(aw); Din = din;
        ResEn = res; Ares = 5'(ar);
        for (int c = 0; c < 2; c++) begin
            if (rd) begin
                r = model_read(c, a1, wr, aw, din);
                h_d1[c] = r[32:1]; h_b1[c] = r[0];
                r = model_read(c, a2, wr, aw, din);
                h_d2[c] = r[32:1]; h_b2[c] = r[0];
            end
            e[c] = '{d1: h_d1[c], b1: h_b1[c], d2: h_d2[c], b2: h_b2[c]};
            if (wr && writable(c, aw)) begin
                m_reg[c][aw]  = din;
                m_busy[c][aw] = 1'b0;
            end
            if (res && writable(c, ar)) m_busy[c][ar] = 1'b1;
        end
        @(posedge Clk);
        q_a.push_back(e[0]);
        q_b.push_back(e[1]);
        #1;
    endtask

    // Monitor: outputs are registered, so mid-cycle they reflect the last edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge Clk);
            if (q_a.size() > 0) begin
                e = q_a.pop_front();
                check("a_dout1", a_d1, e.d1);
                check("a_busy1", 32'(a_b1), 32'(e.b1));
                check("a_dout2", a_d2, e.d2);
                check("a_busy2", 32'(a_b2), 32'(e.b2));
            end
            if (q_b.size() > 0) begin
                e = q_b.pop_front();
                check("b_dout1", b_d1, e.d1);
                check("b_busy1", 32'(b_b1), 32'(e.b1));
                check("b_dout2", b_d2, e.d2);
                check("b_busy2", 32'(b_b2), 32'(e.b2));
            end
        end
    end

    task automatic check_outputs_zero(input string tag);
        check({tag, "_a_dout1"}, a_d1, 32'h0);
        check({tag, "_a_dout2"}, a_d2, 32'h0);
        check({tag, "_a_busy"}, 32'({a_b1, a_b2}), 32'h0);
        check({tag, "_b_dout1"}, b_d1, 32'h0);
        check({tag, "_b_dout2"}, b_d2, 32'h0);
        check({tag, "_b_busy"}, 32'({b_b1, b_b2}), 32'h0);
    endtask

    // Assert reset between edges, after the monitor has consumed the last edge.
    task automatic mid_reset();
        @(negedge Clk);
        #1;
        Rst = 1'b1;
        #1;
        check_outputs_zero("async_rst");
        model_reset();
        #1;
        Rst = 1'b0;
        RdEn = 1'b0; WrEn = 1'b0; ResEn = 1'b0;
        @(posedge Clk);
        #1;
    endtask

    initial begin
        logic [31:0] rd;
        int a1, a2, aw;
        model_reset();
        repeat (3) @(posedge Clk);
        #1;
        check_outputs_zero("reset");
        Rst = 1'b0;

        // All registers empty and idle after reset.
        for (int a = 1; a < 32; a++) cycle(1, a, a, 0, 0, 0, 0, 0);

        // Simple write then read on both ports.
        cycle(0, 0, 0, 1, 1, 32'd1, 0, 0);
        cycle(1, 1, 1, 0, 0, 0, 0, 0);

        // Write and read the same register on the same edge, then re-read.
        cycle(1, 5, 5, 1, 5, 32'hDEADBEEF, 0, 0);
        cycle(1, 5, 5, 0, 0, 0, 0, 0);

        // Write and reserve register 0.
        cycle(0, 0, 0, 1, 0, 32'hFFFFFFFF, 1, 0);
        cycle(1, 0, 0, 0, 0, 0, 0, 0);

        // Reserve, write-clear, then reserve+write together.
        cycle(0, 0, 0, 0, 0, 0, 1, 7);
        cycle(1, 1, 7, 0, 0, 0, 0, 0);
        cycle(0, 0, 0, 1, 7, 32'h55, 0, 0);
        cycle(1, 1, 7, 0, 0, 0, 0, 0);
        cycle(0, 0, 0, 1, 7, 32'h99, 1, 7);
        cycle(1, 1, 7, 0, 0, 0, 0, 0);

        // Bypassed read of a register reserved on the same edge.
        cycle(1, 9, 9, 1, 9, 32'h1234, 1, 9);
        cycle(1, 9, 9, 0, 0, 0, 0, 0);

        // Read hold while writes continue underneath.
        cycle(0, 5, 5, 1, 5, 32'hCAFE, 1, 6);
        cycle(0, 6, 6, 0, 0, 0, 0, 0);
        cycle(1, 6, 5, 0, 0, 0, 0, 0);

        // Addresses beyond the variant's 24 registers.
        cycle(0, 0, 0, 1, 30, 32'h3030, 1, 30);
        cycle(1, 30, 23, 0, 0, 0, 0, 0);

        // Reset mid-operation wipes stored data.
        cycle(0, 0, 0, 1, 3, 32'hA5A5A5A5, 0, 0);
        cycle(1, 3, 3, 0, 0, 0, 0, 0);
        mid_reset();
        cycle(1, 3, 3, 0, 0, 0, 0, 0);

        // Randomised traffic, biased toward address collisions.
        for (int n = 0; n < 600; n++) begin
            rd = $urandom;
            aw = int'($urandom_range(0, 31));
            a1 = (rd[3:2] == 2'b00) ? aw : int'($urandom_range(0, 31));
            a2 = (rd[5:4] == 2'b00) ? aw : int'($urandom_range(0, 31));
            cycle(rd[7:6] != 2'b00, a1, a2, rd[8], aw, $urandom,
                  rd[11:10] == 2'b00, (rd[12]) ? aw : int'($urandom_range(0, 31)));
        end

        RdEn = 1'b0; WrEn = 1'b0; ResEn = 1'b0;
        for (int t = 0; t < 10 && (q_a.size() > 0 || q_b.size() > 0); t++) @(posedge Clk);
        @(negedge Clk);
        #1;
        check("drain_pending", 32'(q_a.size() + q_b.size()), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
- Parametrised successor to the team's 2-read/1-write register file, for the pipelined datapath.
- Configurable width and depth; optional hardwired-zero register 0.
- Synchronous (registered) reads with write-to-read bypass.
- Per-register busy scoreboard, so the issue stage can detect pending writes (RAW hazards).

Parameters:
- DATA_W, 32, register width in bits
- ADDR_W, 5, address width
- NUM_REGS, 32, implemented registers (must be ≤ 2**ADDR_W)
- ZERO_REG, 1, 1 = register 0 always reads 0, and writes/reservations to it are ignored
- BYPASS, 1, 1 = a same-cycle write is forwarded to a matching read

Ports:
- Clk  in  1  clock, rising-edge
- Rst  in  1  asynchronous, active-high reset
- Ard1  in  ADDR_W  read address, port 1
- Ard2  in  ADDR_W  read address, port 2
- RdEn  in  1  read enable; when 0, Dout/Busy outputs hold
- Awr  in  ADDR_W  write address
- Din  in  DATA_W  write data
- WrEn  in  1  write enable; a write also clears busy[Awr]
- Ares  in  ADDR_W  reservation address
- ResEn  in  1  sets busy[Ares]
- Dout1  out  DATA_W  registered read data, port 1
- Dout2  out  DATA_W  registered read data, port 2
- Busy1  out  1  registered busy flag for Ard1
- Busy2  out  1  registered busy flag for Ard2

Behaviour:
- Reset (Rst=1, async): all registers = 0, all busy bits = 0, Dout1/Dout2 = 0, Busy1/Busy2 = 0. Held while Rst=1.
- Write: at the Clk edge with WrEn=1, reg[Awr] <= Din and busy[Awr] <= 0.
- Read latency: 1 cycle. When RdEn=1 at edge N, Dout1/Busy1 show the state for Ard1 sampled at edge N; valid after edge N. Port 2 behaves the same.
- RdEn=0: outputs hold their previous values. Writes and reservations still take effect.
- Bypass (BYPASS=1): WrEn=1, RdEn=1 and Ard1==Awr in the same cycle gives Dout1 = Din and Busy1 = 0 after the edge. Port 2 behaves the same.
- Bypass off (BYPASS=0): the same case returns the old register contents and old busy value.
- Reservation: at the edge with ResEn=1, busy[Ares] <= 1.
- ResEn and WrEn to the same address in the same cycle: reservation wins (busy=1), data is still written.
- Bypass read of a register reserved in the same cycle: Busy shows the pre-edge busy value, or 0 when bypassed. A new reservation is visible only from the next read.
- ZERO_REG=1: address 0 always reads Dout=0 and Busy=0. Writes and reservations to address 0 are dropped.
- Address ≥ NUM_REGS: reads return 0 / not busy; writes and reservations are dropped.
- Both ports may read the same address; both return identical results.
- Reset asserted mid-operation: the state clears immediately (async). The first write is accepted at the first rising edge after Rst deasserts.
- No combinational path from inputs to outputs.

Decomposition:
- Shared package/header `regfile_pkg`: default DATA_W/ADDR_W/NUM_REGS constants and the ZERO_ADDR constant.
- One sub-module, `regfile_rdport`: a single read port containing the address-range check, zero-register masking, bypass mux and output register. It is instantiated twice.
- Storage, write logic and the busy vector stay in the top level.

Test Plan:
1. Reset → all outputs 0. Then read addresses 1..31 with RdEn=1 → every Dout = 0, Busy = 0.
2. Write Awr=1, Din=32'd1, WrEn=1. Next cycle read Ard1=Ard2=1 → Dout1 = Dout2 = 32'd1 one cycle after the read edge.
3. Write Awr=5, Din=32'hDEADBEEF with Ard1=5 and RdEn=1 in the same cycle:
   - BYPASS=1 → Dout1 = 32'hDEADBEEF after that edge.
   - BYPASS=0 → Dout1 = 0, then 32'hDEADBEEF on the next read.
4. Write Awr=0, Din=32'hFFFFFFFF, plus ResEn with Ares=0; then read Ard1=0 → Dout1 = 0, Busy1 = 0 (ZERO_REG=1).
5. ResEn, Ares=7 → next read of Ard2=7 gives Busy2 = 1. Then WrEn, Awr=7, Din=32'h55 → next read gives Busy2 = 0, Dout2 = 32'h55. Then ResEn and WrEn to 7 in the same cycle → next read gives Busy2 = 1, Dout2 = new Din.
6. Write reg 3 = 32'hA5A5A5A5, pulse Rst mid-cycle (between edges) → Dout1/Dout2 go to 0 immediately; a subsequent read of 3 gives 0.
